// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - SPI master control core: sclk divider, bit/byte counters, command sequencer
module spi_cmd_sequencer #(
  parameter int DIV_HALF = 10,
  parameter int GAP_SCLK = 4
) (
  input  logic       clk,
  input  logic       power_btn,
  output logic       sclk,
  output logic       sclk_rise,
  output logic       cs,
  output logic       transfer,
  output logic       receive,
  output logic [1:0] data_select,
  output logic       load,
  output logic [1:0] byte_count,
  output logic [2:0] bit_count,
  output logic       done
);

  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int GW = (GAP_SCLK > 1) ? $clog2(GAP_SCLK) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_GAP, S_RX_GAP, S_RX} state_t;

  state_t          state, state_nxt;
  logic [1:0]      ds, ds_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic [DW-1:0]   div_cnt;
  logic            first_wrap;
  logic            div_wrap;
  logic            active;
  logic [1:0]      last_byte;

  // The first wrap after reset is swallowed so sclk idles low for a full period.
  assign div_wrap  = (div_cnt == DW'(DIV_HALF - 1));
  assign sclk_rise = div_wrap & ~sclk & ~first_wrap;

  always_ff @(posedge clk or negedge power_btn) begin
    if (!power_btn) begin
      div_cnt    <= '0;
      sclk       <= 1'b0;
      first_wrap <= 1'b1;
    end else if (div_wrap) begin
      div_cnt <= '0;
      if (first_wrap) first_wrap <= 1'b0;
      else            sclk       <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign active    = (state == S_CMD) || (state == S_RX);
  assign last_byte = (state == S_CMD && ds == 2'd2) ? 2'd1 : 2'd2;
  assign done      = sclk_rise & active & (bit_count == 3'd7) & (byte_count == last_byte);
  assign load      = sclk_rise & (state == S_CMD) & (bit_count == 3'd0);
  assign data_select = ds;

  // Clearing on done keeps byte_count below the frame size.
  always_ff @(posedge clk or negedge power_btn) begin
    if (!power_btn) begin
      bit_count  <= 3'd0;
      byte_count <= 2'd0;
    end else if (!active || (sclk_rise && done)) begin
      bit_count  <= 3'd0;
      byte_count <= 2'd0;
    end else if (sclk_rise) begin
      bit_count <= bit_count + 3'd1;
      if (bit_count == 3'd7) byte_count <= byte_count + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge power_btn) begin
    if (!power_btn) begin
      state   <= S_IDLE;
      ds      <= 2'd0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ds      <= ds_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ds_nxt    = ds;
    gap_nxt   = gap_cnt;
    cs        = 1'b1;
    transfer  = 1'b0;
    receive   = 1'b0;
    case (state)
      S_IDLE: begin
        if (sclk_rise) state_nxt = S_CMD;
      end
      S_CMD: begin
        cs       = 1'b0;
        transfer = 1'b1;
        if (done) begin
          state_nxt = (ds == 2'd3) ? S_RX_GAP : S_GAP;
          gap_nxt   = '0;
        end
      end
      S_GAP: begin
        if (sclk_rise) begin
          if (gap_cnt == GW'(GAP_SCLK - 1)) begin
            state_nxt = S_CMD;
            ds_nxt    = ds + 2'd1;
            gap_nxt   = '0;
          end else begin
            gap_nxt = gap_cnt + GW'(1);
          end
        end
      end
      S_RX_GAP: begin
        if (sclk_rise) begin
          if (gap_cnt == GW'(GAP_SCLK - 1)) begin
            state_nxt = S_RX;
            gap_nxt   = '0;
          end else begin
            gap_nxt = gap_cnt + GW'(1);
          end
        end
      end
      S_RX: begin
        cs      = 1'b0;
        receive = 1'b1;
        if (done) begin
          state_nxt = S_RX_GAP;
          gap_nxt   = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - directed bench for spi_cmd_sequencer (default and fast parameter sets)
module tb_spi_cmd_sequencer;

  localparam int LIM = 6000;

  logic clk = 1'b0;
  logic power_btn = 1'b0;
  logic use_b = 1'b0;

  always #5 clk = ~clk;

  logic       sclk_a, rise_a, cs_a, tx_a, rx_a, load_a, done_a;
  logic [1:0] ds_a, byte_a;
  logic [2:0] bit_a;
  logic       sclk_b, rise_b, cs_b, tx_b, rx_b, load_b, done_b;
  logic [1:0] ds_b, byte_b;
  logic [2:0] bit_b;

  spi_cmd_sequencer u_dut_a (
    .clk(clk), .power_btn(power_btn), .sclk(sclk_a), .sclk_rise(rise_a), .cs(cs_a),
    .transfer(tx_a), .receive(rx_a), .data_select(ds_a), .load(load_a),
    .byte_count(byte_a), .bit_count(bit_a), .done(done_a)
  );

  spi_cmd_sequencer #(.DIV_HALF(2), .GAP_SCLK(1)) u_dut_b (
    .clk(clk), .power_btn(power_btn), .sclk(sclk_b), .sclk_rise(rise_b), .cs(cs_b),
    .transfer(tx_b), .receive(rx_b), .data_select(ds_b), .load(load_b),
    .byte_count(byte_b), .bit_count(bit_b), .done(done_b)
  );

  wire       m_sclk = use_b ? sclk_b : sclk_a;
  wire       m_rise = use_b ? rise_b : rise_a;
  wire       m_cs   = use_b ? cs_b   : cs_a;
  wire       m_tx   = use_b ? tx_b   : tx_a;
  wire       m_rx   = use_b ? rx_b   : rx_a;
  wire       m_load = use_b ? load_b : load_a;
  wire       m_done = use_b ? done_b : done_a;
  wire [1:0] m_ds   = use_b ? ds_b   : ds_a;
  wire [1:0] m_byte = use_b ? byte_b : byte_a;
  wire [2:0] m_bit  = use_b ? bit_b  : bit_a;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"}, m_sclk, 0);
    check({tag, "_rise"}, m_rise, 0);
    check({tag, "_cs"}, m_cs, 1);
    check({tag, "_transfer"}, m_tx, 0);
    check({tag, "_receive"}, m_rx, 0);
    check({tag, "_ds"}, m_ds, 0);
    check({tag, "_load"}, m_load, 0);
    check({tag, "_done"}, m_done, 0);
    check({tag, "_byte"}, m_byte, 0);
    check({tag, "_bit"}, m_bit, 0);
  endtask

  // Waits for cs low, then counts ticks in the low window and in the following high gap.
  task automatic run_frame(input string tag, input int exp_len, input int exp_ds, input int exp_tx,
                           input int exp_gap, input int exp_loads);
    int guard, len, dones, loads, gap, first_load, load_sp, d_byte, d_bit, max_bit, ds, tx, rx;
    len = 0; dones = 0; loads = 0; gap = 0; first_load = -1; load_sp = 0;
    d_byte = -1; d_bit = -1; max_bit = 0;
    guard = 0;
    while (m_cs !== 1'b0 && guard < LIM) begin
      @(posedge clk); #1; guard++;
    end
    check({tag, "_cs_fall_timeout"}, int'(guard < LIM), 1);
    ds = m_ds; tx = m_tx; rx = m_rx;
    guard = 0;
    while (m_cs === 1'b0 && guard < LIM) begin
      if (m_rise) begin
        if (m_load) begin
          if (first_load < 0) first_load = len;
          else if (load_sp == 0) load_sp = len - first_load;
          loads++;
        end
        if (m_done) begin
          dones++; d_byte = m_byte; d_bit = m_bit;
        end
        if (int'(m_bit) > max_bit) max_bit = m_bit;
        len++;
      end
      @(posedge clk); #1; guard++;
    end
    check({tag, "_cs_rise_timeout"}, int'(guard < LIM), 1);
    guard = 0;
    while (m_cs === 1'b1 && guard < LIM) begin
      if (m_rise) gap++;
      if (m_done || m_load) dones += 100;
      @(posedge clk); #1; guard++;
    end
    check({tag, "_gap_timeout"}, int'(guard < LIM), 1);
    check({tag, "_len"}, len, exp_len);
    check({tag, "_ds"}, ds, exp_ds);
    check({tag, "_transfer"}, tx, exp_tx);
    check({tag, "_receive"}, rx, 1 - exp_tx);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_loads"}, loads, exp_loads);
    check({tag, "_gap"}, gap, exp_gap);
    check({tag, "_done_bit"}, d_bit, 7);
    check({tag, "_done_byte"}, d_byte, exp_len / 8 - 1);
    check({tag, "_max_bit"}, max_bit, 7);
    if (exp_loads >= 2) check({tag, "_load_spacing"}, load_sp, 8);
  endtask

  task automatic measure_period(input string tag, input int exp_period, input int exp_high);
    int n, highs;
    n = 0; highs = 0;
    while (!m_rise && n < LIM) begin
      @(posedge clk); #1; n++;
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (m_sclk) highs++;
    end while (!m_rise && n < LIM);
    check({tag, "_period"}, n, exp_period);
    check({tag, "_high"}, highs, exp_high);
  endtask

  initial begin
    int n;
    int guard;
    int lens[5];
    lens = '{24, 24, 16, 24, 24};

    // Reset hold and first-tick latency
    repeat (100) @(posedge clk);
    #1;
    check_reset_outputs("hold");
    @(negedge clk); power_btn = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!m_rise && n < 100);
    check("first_rise_latency", n, 19);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!m_rise && n < 100);
    check("sclk_period", n, 20);

    // Command sequence and receive loop from a clean start
    @(negedge clk); power_btn = 1'b0;
    #1;
    check_reset_outputs("rst2");
    repeat (5) @(posedge clk);
    @(negedge clk); power_btn = 1'b1;
    run_frame("cmd0", 24, 0, 1, 4, 3);
    run_frame("cmd1", 24, 1, 1, 4, 3);
    run_frame("cmd2", 16, 2, 1, 4, 2);
    run_frame("cmd3", 24, 3, 1, 4, 3);
    for (int i = 0; i < 3; i++) run_frame($sformatf("rx%0d", i), 24, 3, 0, 4, 0);
    measure_period("a", 20, 10);

    // Mid-frame reset during byte 1 of cmd1
    @(negedge clk); power_btn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); power_btn = 1'b1;
    run_frame("mr_cmd0", 24, 0, 1, 4, 3);
    guard = 0;
    while (!(m_ds == 2'd1 && m_byte == 2'd1) && guard < LIM) begin
      @(posedge clk); #1; guard++;
    end
    check("mr_wait_byte1", int'(guard < LIM), 1);
    #3 power_btn = 1'b0;
    #1;
    check_reset_outputs("mr");
    repeat (4) @(posedge clk);
    @(negedge clk); power_btn = 1'b1;
    run_frame("mr_restart", 24, 0, 1, 4, 3);

    // Fast parameter set
    @(negedge clk); power_btn = 1'b0;
    use_b = 1'b1;
    #1;
    check_reset_outputs("b_rst");
    repeat (3) @(posedge clk);
    @(negedge clk); power_btn = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!m_rise && n < 100);
    check("b_first_rise_latency", n, 3);
    @(negedge clk); power_btn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); power_btn = 1'b1;
    for (int i = 0; i < 5; i++)
      run_frame($sformatf("b_f%0d", i), lens[i], (i < 3) ? i : 3, (i < 4) ? 1 : 0, 1,
                (i < 4) ? lens[i] / 8 : 0);
    measure_period("b", 4, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
